// File: rtl/cfgrom_csb_arb.sv
// Round-robin CSB arbiter sharing the cfgrom target between two requesters,
// with single outstanding transaction tracking and a response timeout.
module cfgrom_csb_arb #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic [62:0] s0_req_pd,
  input  logic        s0_req_pvld,
  output logic        s0_req_prdy,
  input  logic [62:0] s1_req_pd,
  input  logic        s1_req_pvld,
  output logic        s1_req_prdy,
  output logic [33:0] s0_resp_pd,
  output logic        s0_resp_valid,
  output logic [33:0] s1_resp_pd,
  output logic        s1_resp_valid,
  output logic [62:0] csb2cfgrom_req_pd,
  output logic        csb2cfgrom_req_pvld,
  input  logic        csb2cfgrom_req_prdy,
  input  logic [33:0] cfgrom2csb_resp_pd,
  input  logic        cfgrom2csb_resp_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic             needs_resp_q, needs_resp_d;
  logic [62:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [33:0]      s0_rpd_q, s0_rpd_d, s1_rpd_q, s1_rpd_d;
  logic             s0_rvld_q, s0_rvld_d, s1_rvld_q, s1_rvld_d;

  logic             gnt0, gnt1;
  logic [62:0]      sel_pd;
  logic             sel_needs;
  logic             fwd_vld;
  logic [33:0]      fwd_pd;

  // last_grant_q==1 means s1 was granted last, so s0 wins a tie.
  assign gnt1      = s1_req_pvld & (~s0_req_pvld | ~last_grant_q);
  assign gnt0      = s0_req_pvld & ~gnt1;
  assign sel_pd    = gnt1 ? s1_req_pd : s0_req_pd;
  assign sel_needs = ~sel_pd[54] | sel_pd[55];

  always_comb begin
    state_d             = state_q;
    last_grant_d        = last_grant_q;
    owner_d             = owner_q;
    needs_resp_d        = needs_resp_q;
    hold_d              = hold_q;
    cnt_d               = cnt_q;
    s0_req_prdy         = 1'b0;
    s1_req_prdy         = 1'b0;
    csb2cfgrom_req_pvld = 1'b0;
    fwd_vld             = 1'b0;
    fwd_pd              = cfgrom2csb_resp_pd;
    unique case (state_q)
      ST_IDLE: begin
        s0_req_prdy = gnt0;
        s1_req_prdy = gnt1;
        if (gnt0 | gnt1) begin
          hold_d       = sel_pd;
          owner_d      = gnt1;
          needs_resp_d = sel_needs;
          last_grant_d = gnt1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        csb2cfgrom_req_pvld = 1'b1;
        if (csb2cfgrom_req_prdy) begin
          if (needs_resp_q) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A real response wins over a timeout in the same cycle.
        if (cfgrom2csb_resp_valid) begin
          fwd_vld = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          fwd_vld = 1'b1;
          fwd_pd  = {hold_q[54], 1'b1, 32'h0};
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s0_rvld_d = 1'b0;
    s1_rvld_d = 1'b0;
    s0_rpd_d  = s0_rpd_q;
    s1_rpd_d  = s1_rpd_q;
    if (fwd_vld) begin
      if (owner_q) begin
        s1_rvld_d = 1'b1;
        s1_rpd_d  = fwd_pd;
      end else begin
        s0_rvld_d = 1'b1;
        s0_rpd_d  = fwd_pd;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      needs_resp_q <= 1'b0;
      hold_q       <= '0;
      cnt_q        <= '0;
      s0_rpd_q     <= '0;
      s1_rpd_q     <= '0;
      s0_rvld_q    <= 1'b0;
      s1_rvld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      needs_resp_q <= needs_resp_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      s0_rpd_q     <= s0_rpd_d;
      s1_rpd_q     <= s1_rpd_d;
      s0_rvld_q    <= s0_rvld_d;
      s1_rvld_q    <= s1_rvld_d;
    end
  end

  assign csb2cfgrom_req_pd = hold_q;
  assign s0_resp_pd        = s0_rpd_q;
  assign s1_resp_pd        = s1_rpd_q;
  assign s0_resp_valid     = s0_rvld_q;
  assign s1_resp_valid     = s1_rvld_q;

endmodule

// File: tb/tb_cfgrom_csb_arb.sv
// Bench for cfgrom_csb_arb: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin/response model.
module tb_cfgrom_csb_arb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [62:0] s0_pd = '0, s1_pd = '0;
  logic        s0_vld = 1'b0, s1_vld = 1'b0;
  logic        s0_prdy, s1_prdy;
  logic [33:0] s0_rpd, s1_rpd;
  logic        s0_rv, s1_rv;
  logic [62:0] m_pd;
  logic        m_pvld;
  logic        m_prdy = 1'b0;
  logic [33:0] r_pd = '0;
  logic        r_vld = 1'b0;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          last_m = 1'b1;
  logic [33:0] exp_rpd [2];

  always #5 clk = ~clk;

  cfgrom_csb_arb #(.TIMEOUT(TO), .CNT_W(10)) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rstn      (rst_n),
    .s0_req_pd            (s0_pd),
    .s0_req_pvld          (s0_vld),
    .s0_req_prdy          (s0_prdy),
    .s1_req_pd            (s1_pd),
    .s1_req_pvld          (s1_vld),
    .s1_req_prdy          (s1_prdy),
    .s0_resp_pd           (s0_rpd),
    .s0_resp_valid        (s0_rv),
    .s1_resp_pd           (s1_rpd),
    .s1_resp_valid        (s1_rv),
    .csb2cfgrom_req_pd    (m_pd),
    .csb2cfgrom_req_pvld  (m_pvld),
    .csb2cfgrom_req_prdy  (m_prdy),
    .cfgrom2csb_resp_pd   (r_pd),
    .cfgrom2csb_resp_valid(r_vld)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_no_resp(input string tag);
    chk({tag, "_s0_rv"}, 64'(s0_rv), 64'(0));
    chk({tag, "_s1_rv"}, 64'(s1_rv), 64'(0));
    chk({tag, "_s0_rpd"}, 64'(s0_rpd), 64'(exp_rpd[0]));
    chk({tag, "_s1_rpd"}, 64'(s1_rpd), 64'(exp_rpd[1]));
  endtask

  // One complete transaction. rlat<0 or rlat>TO means the cfgrom stays silent.
  task automatic run_txn(input bit use0, input bit use1,
                         input logic [62:0] pd0, input logic [62:0] pd1,
                         input int pdly, input int rlat, input bit late,
                         input logic [1:0] rhi, input logic [31:0] rdata);
    int          win;
    logic [62:0] wpd;
    bit          needs;
    logic [33:0] rpd;
    if (use0 && use1) win = last_m ? 0 : 1;
    else              win = use1 ? 1 : 0;
    wpd   = (win == 1) ? pd1 : pd0;
    needs = !wpd[54] || wpd[55];
    s0_pd = pd0; s0_vld = use0;
    s1_pd = pd1; s1_vld = use1;
    m_prdy = 1'b0;
    #1;
    chk("idle_s0_prdy", 64'(s0_prdy), 64'(win == 0));
    chk("idle_s1_prdy", 64'(s1_prdy), 64'(win == 1));
    tick;
    last_m = (win == 1);
    if (win == 0) s0_vld = 1'b0; else s1_vld = 1'b0;
    for (int i = 0; i < pdly; i++) begin
      chk("req_pvld_bp", 64'(m_pvld), 64'(1));
      chk("req_pd_bp", 64'(m_pd), 64'(wpd));
      chk("req_s0_prdy_bp", 64'(s0_prdy), 64'(0));
      chk("req_s1_prdy_bp", 64'(s1_prdy), 64'(0));
      tick;
    end
    chk("req_pvld", 64'(m_pvld), 64'(1));
    chk("req_pd", 64'(m_pd), 64'(wpd));
    m_prdy = 1'b1;
    tick;
    m_prdy = 1'b0;
    if (!needs) begin
      chk("posted_pvld_low", 64'(m_pvld), 64'(0));
      chk_no_resp("posted");
      return;
    end
    if (rlat >= 0 && rlat <= TO) begin
      for (int k = 0; k < rlat; k++) begin
        chk_no_resp("wait");
        tick;
      end
      chk_no_resp("wait_last");
      r_pd  = {rhi, rdata};
      r_vld = 1'b1;
      rpd   = r_pd;
      tick;
      r_vld = 1'b0;
    end else begin
      for (int k = 0; k <= TO; k++) begin
        chk_no_resp("wait_to");
        tick;
      end
      rpd = {wpd[54], 1'b1, 32'h0};
    end
    exp_rpd[win] = rpd;
    chk("resp_s0_rv", 64'(s0_rv), 64'(win == 0));
    chk("resp_s1_rv", 64'(s1_rv), 64'(win == 1));
    chk("resp_s0_rpd", 64'(s0_rpd), 64'(exp_rpd[0]));
    chk("resp_s1_rpd", 64'(s1_rpd), 64'(exp_rpd[1]));
    if (late) begin
      s0_vld = 1'b0;
      s1_vld = 1'b0;
      r_pd   = {2'b01, 32'hBADC0FFE};
      r_vld  = 1'b1;
      tick;
      r_vld  = 1'b0;
      chk_no_resp("late_drop");
      chk("late_pvld", 64'(m_pvld), 64'(0));
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    exp_rpd[0] = '0;
    exp_rpd[1] = '0;
    #2;
    chk("rst_m_pvld", 64'(m_pvld), 64'(0));
    chk("rst_m_pd", 64'(m_pd), 64'(0));
    chk("rst_s0_prdy", 64'(s0_prdy), 64'(0));
    chk("rst_s1_prdy", 64'(s1_prdy), 64'(0));
    chk_no_resp("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;

    // single read from s0
    run_txn(1'b1, 1'b0, 63'h10, 63'h0, 0, 2, 1'b0, 2'b00, 32'hDEADBEEF);
    // contention: both reading, alternating grants
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 1'b1, 63'h20 + 63'(i), 63'h30 + 63'(i), 0, 0, 1'b0, 2'b00, 32'h1000 + 32'(i));
    // backpressure from cfgrom
    run_txn(1'b1, 1'b1, 63'h44, 63'h55, 5, 1, 1'b0, 2'b00, 32'hCAFE0001);
    // posted write from s1, then s0 read accepted the following cycle
    run_txn(1'b0, 1'b1, 63'h0, (63'h1 << 54) | (63'h1234 << 22) | 63'h40, 0, 0, 1'b0, 2'b00, 32'h0);
    run_txn(1'b1, 1'b0, 63'h60, 63'h0, 0, 1, 1'b0, 2'b00, 32'h600D600D);
    // timeout followed by a late response
    run_txn(1'b1, 1'b0, 63'h70, 63'h0, 0, -1, 1'b1, 2'b00, 32'h0);
    // response in the same cycle the counter hits the limit
    run_txn(1'b0, 1'b1, 63'h0, 63'h80, 0, TO, 1'b0, 2'b10, 32'h12345678);
    // non-posted write times out with write_ack set
    run_txn(1'b0, 1'b1, 63'h0, (63'h3 << 54) | 63'h90, 1, -1, 1'b0, 2'b00, 32'h0);

    // asynchronous reset while waiting for a response
    s1_vld = 1'b0;
    s0_pd  = 63'h50;
    s0_vld = 1'b1;
    tick;
    s0_vld = 1'b0;
    m_prdy = 1'b1;
    tick;
    m_prdy = 1'b0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    exp_rpd[0] = '0;
    exp_rpd[1] = '0;
    last_m     = 1'b1;
    chk("arst_m_pvld", 64'(m_pvld), 64'(0));
    chk("arst_m_pd", 64'(m_pd), 64'(0));
    chk_no_resp("arst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    r_pd  = 34'h1_2345678;
    r_vld = 1'b1;
    tick;
    r_vld = 1'b0;
    chk_no_resp("arst_drop");
    chk("arst_drop_pvld", 64'(m_pvld), 64'(0));
    run_txn(1'b1, 1'b1, 63'hA0, 63'hB0, 0, 0, 1'b0, 2'b00, 32'hA0A0A0A0);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      bit u0, u1;
      u0 = 1'($urandom_range(0, 1));
      u1 = 1'($urandom_range(0, 1));
      if (!u0 && !u1) u0 = 1'b1;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_txn(u0, u1, ra[62:0], rb[62:0], int'($urandom_range(0, 3)),
              int'($urandom_range(0, TO + 2)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfgrom_csb_arb.md
# cfgrom_csb_arb

Two-port CSB arbiter that shares the single configuration-ROM CSB target between two CSB requesters (s0, s1). It grants one request at a time round-robin, forwards it to the cfgrom request port, and tracks the one outstanding response-expecting transaction. When the response arrives it routes it back to the owning requester. A timeout counter returns an error response if the cfgrom never answers. It sits between the CSB fabric and the cfgrom block.

## Interface
- TIMEOUT, 1023, cycles in WAIT before a synthetic error response; legal range 1..2^CNT_W-1
- CNT_W, 10, timeout counter width
- nvdla_core_clk  in  1  core clock, all state on rising edge
- nvdla_core_rstn  in  1  reset; asynchronous, active-low
- s0_req_pd / s1_req_pd  in  63  CSB request: addr[21:0], wdat[53:22], write[54], nposted[55], [62:56] passed through unmodified
- s0_req_pvld / s1_req_pvld  in  1  request valid
- s0_req_prdy / s1_req_prdy  out  1  request accepted when pvld&prdy
- s0_resp_pd / s1_resp_pd  out  34  response: rdata[31:0], error[32], write_ack[33]
- s0_resp_valid / s1_resp_valid  out  1  one-cycle response pulse, no backpressure
- csb2cfgrom_req_pd  out  63  forwarded request
- csb2cfgrom_req_pvld  out  1  forwarded request valid
- csb2cfgrom_req_prdy  in  1  cfgrom ready
- cfgrom2csb_resp_pd  in  34  cfgrom response, same format as sX_resp_pd
- cfgrom2csb_resp_valid  in  1  cfgrom response pulse

## Operation
- A request needs a response when write==0 (read) or nposted==1. Posted writes get no response.
- The FSM has three states: IDLE, REQ, WAIT.
- IDLE: grant is combinational. If exactly one pvld is high, that port wins. If both are high, the port not granted last wins. last_grant resets to 1, so s0 wins the first tie. The winner's prdy is high; the loser's prdy is low. On handshake: capture pd into hold register, record owner and needs_resp, update last_grant, go to REQ.
- REQ: csb2cfgrom_req_pvld=1 and pd=hold register, stable until csb2cfgrom_req_prdy. On prdy: go to WAIT if needs_resp (counter cleared to 0), otherwise go to IDLE. Both sX_req_prdy are 0.
- WAIT: counter increments each cycle.
  - On cfgrom2csb_resp_valid: register the pd and pulse owner's sX_resp_valid next cycle; go to IDLE.
  - If counter reaches TIMEOUT with no response: pulse owner's resp_valid next cycle with rdata=0, error=1, write_ack=hold write bit; go to IDLE.
  - A response arriving in the same cycle the counter reaches TIMEOUT takes priority; it is forwarded as a normal response.
- A cfgrom response arriving in IDLE or REQ (late after a timeout, or spurious) is dropped and never forwarded.
- The non-owner's resp_valid never asserts.
- Reset mid-transaction: all state returns to IDLE immediately. The hold register and owner are discarded; no response is generated for the discarded transaction.

## Timing
- Reset values:
  - all prdy/pvld/resp_valid outputs 0 (sX_req_prdy goes high combinationally in IDLE once pvld is seen)
  - csb2cfgrom_req_pd 0, sX_resp_pd 0
  - state IDLE, last_grant 1, counter 0
- Upstream accept in cycle N gives csb2cfgrom_req_pvld=1 in cycle N+1.
- cfgrom response in cycle M gives sX_resp_valid in cycle M+1. State is IDLE in M+1, so a new upstream accept is possible in M+1.
- Timeout: prdy handshake at cycle P (counter 0 at P+1) gives error resp_valid at cycle P+TIMEOUT+2.
- Posted write: prdy handshake at cycle P makes IDLE at P+1 and allows the next accept at P+1.
- Throughput: at most one upstream accept per 2 cycles (IDLE→REQ→IDLE with prdy=1 and a posted write).
- sX_resp_pd holds its last value when resp_valid=0.

## Test plan
- Single read: s0 reads addr 0x000010, cfgrom prdy=1, returns rdata 0xDEADBEEF 3 cycles after acceptance -> s0_resp_valid one cycle later with pd={0,0,0xDEADBEEF}; s1_resp_valid stays 0.
- Contention: s0 and s1 both hold read requests continuously, cfgrom answers each in 1 cycle -> grants alternate s0,s1,s0,s1; each response goes only to its owner.
- Backpressure: csb2cfgrom_req_prdy held low 5 cycles -> csb2cfgrom_req_pd/pvld stable all 5 cycles; both sX_req_prdy=0 until prdy.
- Posted write from s1 (write=1, nposted=0), then s0 read -> no response to s1; s0 request accepted the cycle after the s1 master handshake.
- Timeout with TIMEOUT=4: read issued, cfgrom silent -> owner gets resp pd error=1, rdata=0 at P+6. A late cfgrom response 2 cycles later is dropped.
- Async reset asserted in WAIT -> outputs 0 immediately. After release, a tie goes to s0, and a response arriving after release is dropped.
